alu_pipe: RTL and testbench

Parametrised successor to the core's combinational ALU: WIDTH-bit datapath, 4-bit op field, NZCV flags, valid/ready handshake on input and output. Logic and arithmetic ops complete in one registered cycle. Shifts run on an iterative shifter controlled by an FSM. Sits between decode/register-read and writeback; the multi-cycle pipelined core stalls on in_ready/out_valid.

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_comb.sv | 58 +++++
 rtl/alu_pipe.sv | 149 ++++++++++++++
 tb/tb_alu_pipe.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: op encodings, FSM states and
// the writeback flag bundle.
package alu_pkg;

  localparam int unsigned OP_W = 4;

  // Operation encodings; 4'hA..4'hF are illegal and produce a zero result.
  typedef enum logic [OP_W-1:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_AND  = 4'h2,
    ALU_OR   = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_SLT  = 4'h5,
    ALU_SLTU = 4'h6,
    ALU_SLL  = 4'h7,
    ALU_SRL  = 4'h8,
    ALU_SRA  = 4'h9
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Writeback flag bundle, bit order {N,Z,C,V}.
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  function automatic logic is_shift(input logic [OP_W-1:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU datapath: add/sub, logic ops and compares, with flags.
// Shift and illegal codes yield zero here; shifts are handled by alu_pipe.
// Ports:
//   a_i, b_i  : operands
//   op_i      : operation select
//   result_c  : combinational result
//   flags_c   : combinational {N,Z,C,V}
module alu_comb
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [OP_W-1:0]  op_i,
  output logic [WIDTH-1:0] result_c,
  output flags_t           flags_c
);

  logic             sub;
  logic [WIDTH-1:0] b_x;
  logic [WIDTH:0]   sum;
  logic             ovf;
  logic             lt_s;
  logic             lt_u;

  // Shared adder: SUB is A + ~B + 1, so carry-out means no borrow.
  always_comb begin
    sub  = (op_i == ALU_SUB);
    b_x  = sub ? ~b_i : b_i;
    sum  = {1'b0, a_i} + {1'b0, b_x} + (WIDTH+1)'(sub);
    ovf  = (a_i[WIDTH-1] == b_x[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
    lt_s = $signed(a_i) < $signed(b_i);
    lt_u = a_i < b_i;
  end

  // Result mux and flag generation.
  always_comb begin
    result_c = '0;
    flags_c  = '0;
    case (op_i)
      ALU_ADD, ALU_SUB: begin
        result_c  = sum[WIDTH-1:0];
        flags_c.c = sum[WIDTH];
        flags_c.v = ovf;
      end
      ALU_AND:  result_c = a_i & b_i;
      ALU_OR:   result_c = a_i | b_i;
      ALU_XOR:  result_c = a_i ^ b_i;
      ALU_SLT:  result_c = WIDTH'(lt_s);
      ALU_SLTU: result_c = WIDTH'(lt_u);
      default:  result_c = '0;
    endcase
    flags_c.n = result_c[WIDTH-1];
    flags_c.z = (result_c == '0);
  end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU with valid/ready handshake. Non-shift ops complete in one
// registered cycle; shifts iterate up to SHIFT_STEP bits per cycle.
// Ports:
//   clk, rst            : clock, async active-low reset
//   in_valid, in_ready  : input handshake
//   A, B, ALUControl    : operands and op (B[SHAMT_W-1:0] is the shift amount)
//   out_valid, out_ready: output handshake
//   Result, Zero, Negative, Carry, Overflow : registered result and flags
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [OP_W-1:0]  ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Negative,
  output logic             Carry,
  output logic             Overflow
);

  localparam int unsigned SHAMT_W = $clog2(WIDTH);
  // One extra bit so SHIFT_STEP == WIDTH is representable in the compare.
  localparam int unsigned CNT_W   = SHAMT_W + 1;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    shreg_q, shreg_d;
  logic [SHAMT_W-1:0]  rem_q, rem_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    result_q, result_d;
  flags_t              flags_q, flags_d;

  logic [WIDTH-1:0]    comb_res;
  flags_t              comb_flags;
  logic [SHAMT_W-1:0]  shamt;
  logic [SHAMT_W-1:0]  step;
  logic [WIDTH-1:0]    shifted;
  logic                accept;

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .a_i      (A),
    .b_i      (B),
    .op_i     (ALUControl),
    .result_c (comb_res),
    .flags_c  (comb_flags)
  );

  assign shamt    = B[SHAMT_W-1:0];
  assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // One shifter step of min(SHIFT_STEP, remaining) bits.
  always_comb begin
    if (CNT_W'(rem_q) < CNT_W'(SHIFT_STEP)) begin
      step = rem_q;
    end else begin
      step = SHAMT_W'(SHIFT_STEP);
    end
    case (op_q)
      ALU_SLL: shifted = shreg_q << step;
      ALU_SRA: shifted = WIDTH'($signed(shreg_q) >>> step);
      default: shifted = shreg_q >> step;
    endcase
  end

  // Next-state, shifter and writeback.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    rem_d       = rem_q;
    op_d        = op_q;
    result_d    = result_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q && !out_ready;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_shift(ALUControl)) begin
            if (shamt == '0) begin
              // Zero-length shift completes at the accept edge.
              result_d    = A;
              flags_d     = {A[WIDTH-1], (A == '0), 2'b00};
              out_valid_d = 1'b1;
            end else begin
              shreg_d = A;
              rem_d   = shamt;
              op_d    = ALUControl;
              state_d = ST_SHIFT;
            end
          end else begin
            result_d    = comb_res;
            flags_d     = comb_flags;
            out_valid_d = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        shreg_d = shifted;
        rem_d   = rem_q - step;
        // DONE is folded into the last shift edge to keep the latency.
        if (rem_q == step) begin
          result_d    = shifted;
          flags_d     = {shifted[WIDTH-1], (shifted == '0), 2'b00};
          out_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      rem_q       <= '0;
      op_q        <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      rem_q       <= rem_d;
      op_q        <= op_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign Result    = result_q;
  assign Negative  = flags_q.n;
  assign Zero      = flags_q.z;
  assign Carry     = flags_q.c;
  assign Overflow  = flags_q.v;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=32, SHIFT_STEP=4): directed cases
// with literal expectations, then randomized traffic against a transaction model.
module tb_alu_pipe;

  localparam int unsigned W    = 32;
  localparam int unsigned STEP = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  A = '0;
  logic [W-1:0]  B = '0;
  logic [3:0]    op = '0;
  logic          in_ready, out_valid, Zero, Negative, Carry, Overflow;
  logic [W-1:0]  Result;

  int errors = 0;
  int checks = 0;

  alu_pipe #(.WIDTH(W), .SHIFT_STEP(STEP)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (A),
    .B          (B),
    .ALUControl (op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Result     (Result),
    .Zero       (Zero),
    .Negative   (Negative),
    .Carry      (Carry),
    .Overflow   (Overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference ALU: result, {N,Z,C,V} and accept-to-valid latency.
  function automatic void ref_alu(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [3:0] f, output int lat);
    longint sa, sb, s, u;
    int     sh;
    logic   c, v;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    sh  = int'(b[4:0]);
    c   = 1'b0;
    v   = 1'b0;
    lat = 1;
    case (o)
      4'h0: begin
        r = a + b;
        u = longint'({32'd0, a}) + longint'({32'd0, b});
        c = (u >= 64'sd4294967296);
        s = sa + sb;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'h1: begin
        r = a - b;
        c = (a >= b);
        s = sa - sb;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a ^ b;
      4'h5: r = (sa < sb) ? 32'd1 : 32'd0;
      4'h6: r = (a < b) ? 32'd1 : 32'd0;
      4'h7: begin r = a << sh;                  lat = 1 + (sh + STEP - 1) / STEP; end
      4'h8: begin r = a >> sh;                  lat = 1 + (sh + STEP - 1) / STEP; end
      4'h9: begin r = 32'($signed(a) >>> sh);   lat = 1 + (sh + STEP - 1) / STEP; end
      default: r = '0;
    endcase
    f = {r[31], (r == 32'd0), c, v};
  endfunction

  // Transaction model: one op in flight or held; result due at edge 'due'.
  bit           pend = 1'b0;
  int unsigned  cyc = 0;
  int unsigned  due = 0;
  logic [31:0]  m_res = '0;
  logic [3:0]   m_flg = '0;

  always @(posedge clk or negedge rst) begin : model
    bit          ov, busy, rdy;
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
    if (!rst) begin
      pend = 1'b0;
    end else begin
      ov   = pend && (cyc >= due);
      busy = pend && (cyc < due);
      rdy  = !busy && (!ov || out_ready);
      if (ov && out_ready) pend = 1'b0;
      if (in_valid && rdy) begin
        ref_alu(op, A, B, r, f, lat);
        m_res = r;
        m_flg = f;
        pend  = 1'b1;
        due   = cyc + 32'(lat);
      end
      cyc++;
    end
  end

  // Per-cycle compare of DUT against the model.
  always @(negedge clk) begin : compare
    bit exp_ov, exp_ir;
    #1;
    if (rst) begin
      exp_ov = pend && (cyc >= due);
      exp_ir = !(pend && (cyc < due)) && (!exp_ov || out_ready);
      check("out_valid", 64'(out_valid), 64'(exp_ov));
      check("in_ready", 64'(in_ready), 64'(exp_ir));
      if (exp_ov) begin
        check("Result", 64'(Result), 64'(m_res));
        check("nzcv", 64'({Negative, Zero, Carry, Overflow}), 64'(m_flg));
      end
    end
  end

  task automatic do_op(input string name, input logic [3:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] er, input logic [3:0] ef,
                       input int elat);
    int n;
    int guard;
    @(negedge clk);
    op = o; A = a; B = b; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    guard = 0;
    while (!in_ready && guard < 50) begin @(negedge clk); #1; guard++; end
    if (!in_ready) begin
      check({name, " accept"}, 64'd0, 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; A = $urandom; B = $urandom; op = 4'(ALUControlScramble());
    #1;
    n = 1;
    while (!out_valid && n < 40) begin @(negedge clk); #1; n++; end
    check({name, " lat"}, 64'(n), 64'(elat));
    check({name, " res"}, 64'(Result), 64'(er));
    check({name, " nzcv"}, 64'({Negative, Zero, Carry, Overflow}), 64'(ef));
  endtask

  function automatic int ALUControlScramble();
    return int'($urandom_range(0, 15));
  endfunction

  function automatic logic [31:0] rval();
    case ($urandom % 6)
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'h7FFF_FFFF;
      3: return 32'hFFFF_FFFF;
      4: return 32'($urandom % 64);
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;

    // Model pins against hand-computed values.
    ref_alu(4'h0, 32'h7FFF_FFFF, 32'd1, r, f, lat);
    check("model add", {r, 28'd0, f}, {32'h8000_0000, 28'd0, 4'b1001});
    ref_alu(4'h9, 32'h8000_0000, 32'd4, r, f, lat);
    check("model sra", {r, 28'd0, f}, {32'hF800_0000, 28'd0, 4'b1000});
    check("model sra lat", 64'(lat), 64'd2);

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst Result", 64'(Result), 64'd0);
    check("rst nzcv", 64'({Negative, Zero, Carry, Overflow}), 64'd0);
    check("rst in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b1;

    do_op("add ovf",  4'h0, 32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 4'b1001, 1);
    do_op("add wrap", 4'h0, 32'hFFFF_FFFF, 32'd1,         32'h0,         4'b0110, 1);
    do_op("sub eq",   4'h1, 32'd5,         32'd5,         32'h0,         4'b0110, 1);
    do_op("sub neg",  4'h1, 32'd3,         32'd5,         32'hFFFF_FFFE, 4'b1000, 1);
    do_op("and",      4'h2, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 4'b0000, 1);
    do_op("or",       4'h3, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 4'b1000, 1);
    do_op("xor",      4'h4, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'hF0F0_F0F0, 4'b1000, 1);
    do_op("slt",      4'h5, 32'hFFFF_FFFF, 32'd1,         32'd1,         4'b0000, 1);
    do_op("sltu",     4'h6, 32'hFFFF_FFFF, 32'd1,         32'd0,         4'b0100, 1);
    do_op("sll 5",    4'h7, 32'd1,         32'h25,        32'h20,        4'b0000, 3);
    do_op("sll 31",   4'h7, 32'd1,         32'd31,        32'h8000_0000, 4'b1000, 9);
    do_op("sra 4",    4'h9, 32'h8000_0000, 32'd4,         32'hF800_0000, 4'b1000, 2);
    do_op("srl 1",    4'h8, 32'h8000_0000, 32'h21,        32'h4000_0000, 4'b0000, 2);
    do_op("srl 0",    4'h8, 32'hF0,        32'h20,        32'hF0,        4'b0000, 1);
    do_op("illegal",  4'hF, 32'd5,         32'd3,         32'h0,         4'b0100, 1);
    do_op("add 7",    4'h0, 32'd3,         32'd4,         32'd7,         4'b0000, 1);

    // Backpressure: result held, then same-edge handshake and accept.
    @(negedge clk);
    op = 4'h0; A = 32'd2; B = 32'd3; in_valid = 1'b1; out_ready = 1'b0;
    #1;
    check("bp accept ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    A = 32'd10; B = 32'd20;
    #1;
    check("bp first valid", 64'(out_valid), 64'd1);
    check("bp first res", 64'(Result), 64'd5);
    repeat (5) begin
      @(negedge clk);
      #1;
      check("bp in_ready", 64'(in_ready), 64'd0);
      check("bp hold", 64'(Result), 64'd5);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check("bp release ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("bp second valid", 64'(out_valid), 64'd1);
    check("bp second res", 64'(Result), 64'd30);

    // Reset in the middle of a long shift.
    do_op("pre rst", 4'h0, 32'd100, 32'd23, 32'd123, 4'b0000, 1);
    @(negedge clk);
    op = 4'h7; A = 32'd1; B = 32'd31; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst out_valid", 64'(out_valid), 64'd0);
    check("midrst Result", 64'(Result), 64'd0);
    check("midrst nzcv", 64'({Negative, Zero, Carry, Overflow}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("postrst in_ready", 64'(in_ready), 64'd1);
    repeat (12) @(negedge clk);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      op        = 4'($urandom % 16);
      A         = rval();
      B         = rval();
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
